mp_serial_adder: RTL

- Byte-serial multi-precision adder/subtractor for the RSA datapath.
- Streams NBYTES-wide operands through one 8-bit kogge_stone_adder, one byte per clock, LSB first.
- Carry is held in a register between bytes.
- Sits directly upstream of the 8-bit adder: it supplies a/b/ci each cycle and collects sum/co.
- Consumers are the modular-reduction and multiply control logic.

---
 rtl/rsa_pkg.sv | 14 +
 rtl/kogge_stone_adder.sv | 37 +++
 rtl/mp_serial_adder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: definitions shared by the RSA datapath blocks.
//   BYTE_W  - width of one serial digit (one adder slice).
//   state_t - control states of the byte-serial sequencers.
package rsa_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/kogge_stone_adder.sv
// kogge_stone_adder: 8-bit parallel-prefix adder with carry in/out.
//   a, b  - byte operands
//   ci    - carry in
//   sum   - a + b + ci (low 8 bits)
//   co    - carry out of bit 7
module kogge_stone_adder
   import rsa_pkg::*;
(
   input  logic [BYTE_W-1:0] a,
   input  logic [BYTE_W-1:0] b,
   input  logic              ci,
   output logic [BYTE_W-1:0] sum,
   output logic              co
);

   logic [BYTE_W-1:0] p0, g0;
   logic [BYTE_W-1:0] p1, g1;
   logic [BYTE_W-1:0] p2, g2;
   logic [BYTE_W-1:0] g3;

   assign p0 = a ^ b;
   // Carry-in is folded into bit 0's generate, so every prefix that reaches
   // bit 0 already includes it and g3[i] is the carry into bit i+1.
   assign g0 = (a & b) | {{(BYTE_W-1){1'b0}}, p0[0] & ci};

   // Prefix spans 1, 2, 4. Shifted-in zeros leave already-complete low
   // prefixes untouched.
   assign g1 = g0 | (p0 & (g0 << 1));
   assign p1 = p0 & (p0 << 1);
   assign g2 = g1 | (p1 & (g1 << 2));
   assign p2 = p1 & (p1 << 2);
   assign g3 = g2 | (p2 & (g2 << 4));

   assign sum = p0 ^ {g3[BYTE_W-2:0], ci};
   assign co  = g3[BYTE_W-1];

endmodule

// File: rtl/mp_serial_adder.sv
// mp_serial_adder: byte-serial multi-precision adder/subtractor.
// Streams NBYTES-wide operands through one 8-bit kogge_stone_adder, LSB byte
// first, holding the carry in a register between bytes.
//
// Parameters:
//   NBYTES    - operand width in bytes (2..16); W = 8*NBYTES
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   start     - request pulse, only sampled in IDLE
//   sub       - 0 = A+B, 1 = A-B (latched on accepted start)
//   a, b      - operands (latched on accepted start)
//   busy      - high while RUN or DONE
//   done      - one-cycle pulse, result/carry_out valid
//   result    - registered sum/difference, held until next accepted start
//   carry_out - final carry: add = overflow, sub = 1 when A >= B
//
// Build option: MP_SERIAL_ADDER_SUB_EN enables subtraction. Without it the
// sub port is ignored and the block only adds.
module mp_serial_adder
   import rsa_pkg::*;
#(
   parameter int unsigned NBYTES = 4
)
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     sub,
   input  logic [BYTE_W*NBYTES-1:0] a,
   input  logic [BYTE_W*NBYTES-1:0] b,
   output logic                     busy,
   output logic                     done,
   output logic [BYTE_W*NBYTES-1:0] result,
   output logic                     carry_out
);

   localparam int unsigned W  = BYTE_W * NBYTES;
   localparam int unsigned CW = $clog2(NBYTES);
   localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic [W-1:0]      a_q, b_q;
   logic              carry_q;
   logic [CW+2:0]     base;
   logic [BYTE_W-1:0] byte_a, byte_b, byte_sum;
   logic              byte_co;
   logic              init_carry;

   // Byte k starts at bit 8k; {cnt, 3'b000} is that offset at exact width.
   assign base   = {cnt_q, 3'b000};
   assign byte_a = a_q[base +: BYTE_W];

`ifdef MP_SERIAL_ADDER_SUB_EN
   logic sub_q;

   // Two's-complement subtract: invert B and inject 1 as the first carry.
   assign byte_b     = sub_q ? ~b_q[base +: BYTE_W] : b_q[base +: BYTE_W];
   assign init_carry = sub;
`else
   logic unused_sub;

   assign unused_sub = sub;
   assign byte_b     = b_q[base +: BYTE_W];
   assign init_carry = 1'b0;
`endif

   kogge_stone_adder u_adder (
      .a   (byte_a),
      .b   (byte_b),
      .ci  (carry_q),
      .sum (byte_sum),
      .co  (byte_co)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         result    <= '0;
         carry_out <= 1'b0;
`ifdef MP_SERIAL_ADDER_SUB_EN
         sub_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= init_carry;
                  cnt_q   <= '0;
`ifdef MP_SERIAL_ADDER_SUB_EN
                  sub_q   <= sub;
`endif
               end
            end
            ST_RUN: begin
               result[base +: BYTE_W] <= byte_sum;
               carry_q                <= byte_co;
               if (cnt_q == LAST) begin
                  carry_out <= byte_co;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
